// File: rtl/nn_batch_runner.sv
// rtl/nn_batch_runner.sv - batch driver: feeds ROM images to a network and scores its predictions
// One image at a time: fetch, load, pulse network reset, run until prediction or timeout, score.
module nn_batch_runner #(
  parameter  int DATA_WIDTH  = 16,
  parameter  int NUM_INPUTS  = 784,
  parameter  int NUM_CLASSES = 10,
  parameter  int NUM_IMAGES  = 8,
  parameter  int TIMEOUT     = 4096,
  localparam int AW = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int LW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int CW = $clog2(NUM_IMAGES + 1),
  localparam int TW = $clog2(TIMEOUT),
  localparam int IW = NUM_INPUTS * DATA_WIDTH
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] img_addr,
  input  logic [IW-1:0] img_data,
  input  logic [LW-1:0] img_label,
  output logic          nn_reset,
  output logic [IW-1:0] NNin,
  output logic          NNvalid,
  input  logic [LW-1:0] maxIndex,
  input  logic          maxValid,
  output logic          busy,
  output logic          result_valid,
  output logic [AW-1:0] result_index,
  output logic          result_pass,
  output logic          result_timeout,
  output logic [CW-1:0] correct_count,
  output logic [CW-1:0] timeout_count,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_NNRST, S_RUN, S_CHECK, S_FINISH
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] img_cnt;
  logic [TW-1:0] cyc_cnt;
  logic [LW-1:0] label_q;
  logic          run_last;
  logic          img_last;

  assign run_last = (cyc_cnt == TW'(TIMEOUT - 1));
  assign img_last = (img_cnt == AW'(NUM_IMAGES - 1));
  assign img_addr = img_cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_LOAD;
      S_LOAD:   state_nx = S_NNRST;
      S_NNRST:  state_nx = S_RUN;
      S_RUN:    if (maxValid || run_last) state_nx = S_CHECK;
      S_CHECK:  state_nx = img_last ? S_FINISH : S_FETCH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE);
    nn_reset     = (state == S_NNRST);
    NNvalid      = (state == S_RUN);
    result_valid = (state == S_CHECK);
    done         = (state == S_FINISH);
  end

  // Result fields are settled on the RUN exit edge so they are stable throughout CHECK.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      img_cnt        <= '0;
      cyc_cnt        <= '0;
      label_q        <= '0;
      NNin           <= '0;
      result_index   <= '0;
      result_pass    <= 1'b0;
      result_timeout <= 1'b0;
      correct_count  <= '0;
      timeout_count  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          img_cnt        <= '0;
          correct_count  <= '0;
          timeout_count  <= '0;
          result_index   <= '0;
          result_pass    <= 1'b0;
          result_timeout <= 1'b0;
        end
        S_LOAD: begin
          NNin    <= img_data;
          label_q <= img_label;
        end
        S_NNRST: cyc_cnt <= '0;
        S_RUN: begin
          cyc_cnt <= cyc_cnt + TW'(1);
          if (maxValid) begin
            result_index   <= img_cnt;
            result_pass    <= (maxIndex == label_q);
            result_timeout <= 1'b0;
          end else if (run_last) begin
            result_index   <= img_cnt;
            result_pass    <= 1'b0;
            result_timeout <= 1'b1;
          end
        end
        S_CHECK: begin
          if (result_pass)    correct_count <= correct_count + CW'(1);
          if (result_timeout) timeout_count <= timeout_count + CW'(1);
          if (!img_last)      img_cnt       <= img_cnt + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
